hdmi_fill_fifo_fsm: RTL and testbench

- Line-fetch sequencer for the HDMI output path.
- Tracks video timing through toggle-style hsync/vsync inputs and computes the DDR start address of each display line.
- Emits a one-cycle go_fill_fifo request so the DDR read engine refills the pixel FIFO.
- Sits between the timing generator/slave registers and the DDR read master.

---
 rtl/hdmi_fill_pkg.sv | 17 +
 rtl/toggle_to_pulse.sv | 18 +
 rtl/hdmi_fill_fifo_fsm.sv | 104 ++++++++++
 tb/tb_hdmi_fill_fifo_fsm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_fill_pkg.sv
// Shared types and widths for the HDMI line-fetch sequencer.
package hdmi_fill_pkg;

  localparam int ADDR_W = 32;
  localparam int PIX_W  = 16;
  localparam int BPP_W  = 3;
  localparam int PROD_W = PIX_W + BPP_W;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VSYNC,
    ACTIVE,
    ISSUE,
    DONE
  } state_t;

endpackage

// File: rtl/toggle_to_pulse.sv
// Registered XOR edge detector: every level change of sig is one event.
module toggle_to_pulse (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic ev
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= sig;
  end

  assign ev = sig ^ prev;

endmodule

// File: rtl/hdmi_fill_fifo_fsm.sv
// Line-fetch sequencer: turns hsync/vsync toggles into per-line DDR fetch requests.
// Define FILL_FIFO_PREFETCH_EN to request line 0 directly on vsync.
//
// state      | meaning
// IDLE       | disabled, outputs quiet
// WAIT_VSYNC | enabled, waiting for first frame boundary
// ACTIVE     | in frame, waiting for next hsync
// ISSUE      | registering one fetch request for line_base
// DONE       | all lines of the frame fetched, waiting for vsync
module hdmi_fill_fifo_fsm #(
  parameter int NUM_LINES = 480,
  parameter int ADDR_W    = hdmi_fill_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [ADDR_W-1:0] frame_base_addr,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic [15:0]       num_pixels_per_line,
  input  logic [2:0]        num_bytes_per_pixel,
  output logic [ADDR_W-1:0] ddr_addr_to_read,
  output logic              go_fill_fifo
);
  import hdmi_fill_pkg::*;

  localparam int CNT_W = $clog2(NUM_LINES + 1);

`ifdef FILL_FIFO_PREFETCH_EN
  localparam state_t RESTART_ST = ISSUE;
`else
  localparam state_t RESTART_ST = ACTIVE;
`endif

  state_t            state, state_nx;
  logic [ADDR_W-1:0] line_base, line_base_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [CNT_W-1:0]  line_cnt, line_cnt_nx;
  logic              go_q, go_nx;
  logic              hs_ev, vs_ev;
  logic [PROD_W-1:0] packed_stride;
  logic [ADDR_W-1:0] eff_stride;

  toggle_to_pulse u_hs (.clk(clk), .reset(reset), .sig(hsync), .ev(hs_ev));
  toggle_to_pulse u_vs (.clk(clk), .reset(reset), .sig(vsync), .ev(vs_ev));

  assign packed_stride = PROD_W'(num_pixels_per_line) * PROD_W'(num_bytes_per_pixel);
  assign eff_stride    = (line_stride != '0) ? line_stride : ADDR_W'(packed_stride);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      line_base <= '0;
      addr_q    <= '0;
      line_cnt  <= '0;
      go_q      <= 1'b0;
    end else begin
      state     <= state_nx;
      line_base <= line_base_nx;
      addr_q    <= addr_nx;
      line_cnt  <= line_cnt_nx;
      go_q      <= go_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    line_base_nx = line_base;
    addr_nx      = addr_q;
    line_cnt_nx  = line_cnt;
    go_nx        = 1'b0;
    if (!start) begin
      state_nx    = IDLE;
      line_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: state_nx = WAIT_VSYNC;
        WAIT_VSYNC, ACTIVE, DONE: begin
          // vsync outranks a coincident hsync, which is simply dropped
          if (vs_ev) begin
            line_base_nx = frame_base_addr;
            line_cnt_nx  = '0;
            state_nx     = RESTART_ST;
          end else if (hs_ev && state == ACTIVE) begin
            state_nx = ISSUE;
          end
        end
        ISSUE: begin
          go_nx        = 1'b1;
          addr_nx      = line_base;
          line_base_nx = line_base + eff_stride;
          line_cnt_nx  = line_cnt + CNT_W'(1);
          state_nx     = (line_cnt_nx == CNT_W'(NUM_LINES)) ? DONE : ACTIVE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign go_fill_fifo     = go_q;
  assign ddr_addr_to_read = addr_q;

endmodule

// File: tb/tb_hdmi_fill_fifo_fsm.sv
// Scoreboard bench for hdmi_fill_fifo_fsm with a frame/line reference model.
module tb_hdmi_fill_fifo_fsm;

  localparam int TB_LINES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [31:0] frame_base_addr = '0;
  logic [31:0] line_stride = '0;
  logic [15:0] num_pixels_per_line = '0;
  logic [2:0]  num_bytes_per_pixel = '0;
  logic [31:0] ddr_addr_to_read;
  logic        go_fill_fifo;

  hdmi_fill_fifo_fsm #(.NUM_LINES(TB_LINES), .ADDR_W(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .hsync               (hsync),
    .vsync               (vsync),
    .frame_base_addr     (frame_base_addr),
    .line_stride         (line_stride),
    .num_pixels_per_line (num_pixels_per_line),
    .num_bytes_per_pixel (num_bytes_per_pixel),
    .ddr_addr_to_read    (ddr_addr_to_read),
    .go_fill_fifo        (go_fill_fifo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_addr = '0;

  // reference model state: one frame is a base address plus a count of fetched lines
  bit          armed = 1'b0;
  bit          in_frame = 1'b0;
  int          lines = 0;
  logic [31:0] next_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_stride();
    if (line_stride != 32'd0) return line_stride;
    return 32'(int'(num_pixels_per_line) * int'(num_bytes_per_pixel));
  endfunction

  task automatic push_line();
    exp_t e;
    e.addr = next_addr;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
    next_addr = next_addr + model_stride();
    lines++;
  endtask

  task automatic ev(input bit do_hs, input bit do_vs);
    @(negedge clk);
    if (do_hs) hsync = ~hsync;
    if (do_vs) vsync = ~vsync;
    if (armed) begin
      if (do_vs) begin
        in_frame  = 1'b1;
        lines     = 0;
        next_addr = frame_base_addr;
`ifdef FILL_FIFO_PREFETCH_EN
        push_line();
`endif
      end else if (do_hs && in_frame && lines < TB_LINES) begin
        push_line();
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_start(input bit v);
    @(negedge clk);
    start = v;
    if (!v) begin
      armed    = 1'b0;
      in_frame = 1'b0;
    end
    repeat (3) @(negedge clk);
    if (v) armed = 1'b1;
  endtask

  task automatic set_cfg(input logic [31:0] base, input logic [31:0] stride,
                         input logic [15:0] pix, input logic [2:0] bpp);
    @(negedge clk);
    frame_base_addr     = base;
    line_stride         = stride;
    num_pixels_per_line = pix;
    num_bytes_per_pixel = bpp;
  endtask

  // monitor: pops the scoreboard on each pulse and checks the held address otherwise
  always @(negedge clk) begin
    if (reset) begin
      last_addr = '0;
    end else if (mon_en) begin
      if (go_fill_fifo) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: got pulse addr %h expected no pulse (cycle %0d)",
                   ddr_addr_to_read, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_addr", 64'(ddr_addr_to_read), 64'(e.addr));
          check("pulse_cycle", 64'(cyc), 64'(e.cyc));
          last_addr = e.addr;
        end
      end else begin
        check("addr_hold", 64'(ddr_addr_to_read), 64'(last_addr));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_go", 64'(go_fill_fifo), 64'd0);
    check("reset_addr", 64'(ddr_addr_to_read), 64'd0);
    mon_en = 1'b1;

    // basic explicit stride
    set_cfg(32'h1000_0000, 32'h0000_1000, 16'd0, 3'd0);
    set_start(1'b1);
    ev(0, 1);
    repeat (3) ev(1, 0);

    // packed stride 640 px * 4 B
    set_cfg(32'h2000_0000, 32'h0, 16'd640, 3'd4);
    ev(0, 1);
    repeat (2) ev(1, 0);

    // hsync before any vsync is ignored
    set_start(1'b0);
    set_start(1'b1);
    repeat (2) ev(1, 0);
    ev(0, 1);
    ev(1, 0);

    // line limit, then restart
    set_cfg(32'h3000_0000, 32'h0000_0400, 16'd0, 3'd0);
    ev(0, 1);
    repeat (TB_LINES + 2) ev(1, 0);
    ev(0, 1);
    ev(1, 0);

    // coincident hsync/vsync mid-frame: vsync wins
    ev(0, 1);
    ev(1, 0);
    ev(1, 1);
    ev(1, 0);

    // address wrap, then start dropped mid-frame
    set_cfg(32'hFFFF_F800, 32'h0000_1000, 16'd0, 3'd0);
    ev(0, 1);
    repeat (2) ev(1, 0);
    set_start(1'b0);
    repeat (2) ev(1, 0);
    set_start(1'b1);
    ev(1, 0);
    ev(0, 1);
    ev(1, 0);

    // reset mid-frame
    @(negedge clk);
    reset    = 1'b1;
    armed    = 1'b0;
    in_frame = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    ev(1, 0);
    set_cfg(32'h4000_0000, 32'h0000_0100, 16'd0, 3'd0);
    ev(0, 1);
    ev(1, 0);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      logic [31:0] stride;
      stride = ($urandom_range(0, 1) == 0) ? 32'h0 : (32'($urandom_range(1, 4096)) << 4);
      set_cfg($urandom & 32'hFFFF_FFF0, stride, 16'($urandom_range(1, 4000)),
              3'($urandom_range(1, 4)));
      if ($urandom_range(0, 7) == 0) begin
        set_start(1'b0);
        set_start(1'b1);
      end
      ev(0, 1);
      for (int k = 0, n = $urandom_range(0, 6); k < n; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      ev(1, 1);
        else if (r == 1) ev(0, 1);
        else             ev(1, 0);
      end
    end

    repeat (6) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
